i2c_write_master: RTL and testbench

Open-drain I2C master that performs one 3-byte write frame ([slave address, sub-address, data], MSB first) per request. It sits directly downstream of the codec configuration sequencer: it takes the 24-bit word and GO level from the sequencer and returns END/ACK status. It drives the board SCL line and the shared SDA line. The bus clock is generated internally from the system clock.

---
 rtl/i2c_write_master.sv | 122 ++++++++++++
 tb/tb_i2c_write_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_master.sv
// Open-drain I2C master: one 3-byte write frame [address, sub-address, data] per GO rising edge.
// END flags completion; ACK is sticky when any byte of the last frame was NACKed.
module i2c_write_master #(
    parameter int CLK_Freq = 27000000,
    parameter int I2C_Freq = 100000,
    parameter int QDIV     = CLK_Freq / (4 * I2C_Freq)
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [23:0] I2C_DATA,
    input  logic        GO,
    output logic        END,
    output logic        ACK,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);

    localparam int TW = $clog2(QDIV);
    localparam logic [TW-1:0] QLAST = TW'(QDIV - 1);

    typedef enum logic [2:0] {IDLE, START, BIT, ACKB, STOP} stateType;

    stateType    state, stateNext;
    logic        goD;
    logic [TW-1:0] timer;
    logic [1:0]  q;
    logic [2:0]  bitCnt;
    logic [1:0]  byteCnt;
    logic [23:0] shiftReg;
    logic        endFlag, ackFlag;
    logic        sclOut, sdaLow;
    logic        start, tick;

    assign start = GO & ~goD & (state == IDLE);
    assign tick  = (timer == QLAST);

    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= stateNext;
    end

    // Quarter timer, shift register and status flags; a new start overrides everything.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            goD      <= 1'b0;
            timer    <= '0;
            q        <= 2'd0;
            bitCnt   <= 3'd0;
            byteCnt  <= 2'd0;
            shiftReg <= 24'd0;
            endFlag  <= 1'b0;
            ackFlag  <= 1'b0;
        end else begin
            goD <= GO;
            if (start) begin
                shiftReg <= I2C_DATA;
                endFlag  <= 1'b0;
                ackFlag  <= 1'b0;
                bitCnt   <= 3'd0;
                byteCnt  <= 2'd0;
                timer    <= '0;
                q        <= 2'd0;
            end else if (state != IDLE) begin
                if (tick) begin
                    timer <= '0;
                    q     <= q + 2'd1;
                    if (state == ACKB && q == 2'd1 && I2C_SDAT)
                        ackFlag <= 1'b1;
                    if (q == 2'd3) begin
                        case (state)
                            BIT: begin
                                shiftReg <= {shiftReg[22:0], 1'b0};
                                bitCnt   <= bitCnt + 3'd1;
                            end
                            ACKB: if (byteCnt < 2'd2) byteCnt <= byteCnt + 2'd1;
                            STOP: endFlag <= 1'b1;
                            default: ;
                        endcase
                    end
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

    // Bus levels are a pure function of state and quarter; transitions happen on the q3 wrap.
    always_comb begin
        stateNext = state;
        sclOut    = 1'b1;
        sdaLow    = 1'b0;
        case (state)
            IDLE: if (start) stateNext = START;
            START: begin
                sdaLow = (q != 2'd0);
                sclOut = (q != 2'd3);
                if (tick && q == 2'd3) stateNext = BIT;
            end
            BIT: begin
                sdaLow = ~shiftReg[23];
                sclOut = (q == 2'd1) || (q == 2'd2);
                if (tick && q == 2'd3 && bitCnt == 3'd7) stateNext = ACKB;
            end
            ACKB: begin
                sclOut = (q == 2'd1) || (q == 2'd2);
                if (tick && q == 2'd3) stateNext = (byteCnt < 2'd2) ? BIT : STOP;
            end
            STOP: begin
                sdaLow = (q < 2'd2);
                sclOut = (q != 2'd0);
                if (tick && q == 2'd3) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign I2C_SCLK = sclOut;
    assign I2C_SDAT = sdaLow ? 1'b0 : 1'bz;
    assign END      = endFlag;
    assign ACK      = ackFlag;

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: default-rate and QDIV=2 instances share one bus monitor/slave model.
module tb_i2c_write_master;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [23:0] i2cData;
    logic        go;
    logic        sel;
    logic        sclA, sclB, endA, endB, ackA, ackB;
    logic        slaveLow = 1'b0;
    logic [2:0]  ackMask = 3'b111;
    wire         sdaA, sdaB;

    pullup (sdaA);
    pullup (sdaB);
    assign sdaA = (slaveLow && !sel) ? 1'b0 : 1'bz;
    assign sdaB = (slaveLow &&  sel) ? 1'b0 : 1'bz;

    wire scl     = sel ? sclB : sclA;
    wire sdaLine = sel ? sdaB : sdaA;
    wire endSig  = sel ? endB : endA;
    wire ackSig  = sel ? ackB : ackA;
    wire goA     = go & ~sel;
    wire goB     = go & sel;

    i2c_write_master dutA (
        .iCLK(iCLK), .iRST(iRST), .I2C_DATA(i2cData), .GO(goA),
        .END(endA), .ACK(ackA), .I2C_SCLK(sclA), .I2C_SDAT(sdaA)
    );

    i2c_write_master #(.QDIV(2)) dutB (
        .iCLK(iCLK), .iRST(iRST), .I2C_DATA(i2cData), .GO(goB),
        .END(endB), .ACK(ackB), .I2C_SCLK(sclB), .I2C_SDAT(sdaB)
    );

    always #5 iCLK = ~iCLK;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] expQ[$];
    logic       expAckQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Bus monitor and slave: decodes START/STOP, collects bytes on SCL rise, ACKs per ackMask.
    int         bitIdx = 0;
    int         byteNum = 0;
    int         startCnt = 0;
    int         stopCnt = 0;
    logic [7:0] shiftIn = 8'd0;
    logic       sclPrev = 1'b1;
    logic       sdaPrev = 1'b1;

    always @(negedge iCLK) begin
        logic b;
        b = (sdaLine === 1'b0) ? 1'b0 : 1'b1;
        if (sclPrev && scl && sdaPrev && !b) begin
            startCnt++;
            bitIdx   = 0;
            byteNum  = 0;
            slaveLow = 1'b0;
        end else if (sclPrev && scl && !sdaPrev && b) begin
            stopCnt++;
        end else if (!sclPrev && scl) begin
            if (bitIdx < 8) begin
                shiftIn = {shiftIn[6:0], b};
                bitIdx++;
                if (bitIdx == 8) begin
                    checkOutput("byteExpected", expQ.size() != 0, 1);
                    if (expQ.size() != 0)
                        checkOutput($sformatf("byte%0d", byteNum), shiftIn, expQ.pop_front());
                end
            end else begin
                bitIdx = 9;
            end
        end else if (sclPrev && !scl) begin
            if (bitIdx == 8 && byteNum < 3) begin
                slaveLow = ackMask[byteNum];
            end else if (bitIdx == 9) begin
                slaveLow = 1'b0;
                bitIdx   = 0;
                byteNum++;
            end
        end
        sclPrev = scl;
        sdaPrev = b;
    end

    task automatic pushFrame(input logic [23:0] data, input logic [2:0] mask, input logic expAck);
        i2cData = data;
        ackMask = mask;
        expQ.push_back(data[23:16]);
        expQ.push_back(data[15:8]);
        expQ.push_back(data[7:0]);
        expAckQ.push_back(expAck);
    endtask

    task automatic applyStimulus(input logic [23:0] data, input logic [2:0] mask, input logic expAck);
        go = 1'b0;
        @(posedge iCLK); #1;
        pushFrame(data, mask, expAck);
        go = 1'b1;
    endtask

    // The first edge after the call accepts the frame; END must follow 116*QDIV edges later.
    task automatic waitEnd(input int expCycles, input int toggleAt, input string tag);
        int n;
        int s0;
        int p0;
        bit done;
        n = 0; done = 0; s0 = startCnt; p0 = stopCnt;
        while (!done && n <= expCycles + 20) begin
            @(posedge iCLK); #1;
            n++;
            if (n == 1) begin
                checkOutput({tag, "_endCleared"}, endSig, 1'b0);
                s0 = startCnt;
                p0 = stopCnt;
            end
            if (toggleAt > 0 && n == toggleAt)     go = 1'b0;
            if (toggleAt > 0 && n == toggleAt + 1) go = 1'b1;
            if (endSig === 1'b1) done = 1;
        end
        checkOutput({tag, "_endSeen"}, done, 1);
        checkOutput({tag, "_cycles"}, n - 1, expCycles);
        checkOutput({tag, "_ackQueued"}, expAckQ.size() != 0, 1);
        if (expAckQ.size() != 0)
            checkOutput({tag, "_ack"}, ackSig, expAckQ.pop_front());
        checkOutput({tag, "_starts"}, startCnt - s0, 1);
        checkOutput({tag, "_stops"}, stopCnt - p0, 1);
        checkOutput({tag, "_bytesLeft"}, expQ.size(), 0);
    endtask

    initial begin
        int s0;
        int p0;
        bit found;
        iRST = 1'b1; go = 1'b0; sel = 1'b0; i2cData = 24'd0;
        repeat (3) @(posedge iCLK);
        #1;
        checkOutput("rstScl", scl, 1'b1);
        checkOutput("rstSda", sdaLine === 1'b0, 1'b0);
        checkOutput("rstEnd", endSig, 1'b0);
        checkOutput("rstAck", ackSig, 1'b0);
        iRST = 1'b0;

        // Default rate: one ACKed frame, then GO held high must not restart.
        applyStimulus(24'h200227, 3'b111, 1'b0);
        waitEnd(7772, 0, "dflt");
        s0 = startCnt; p0 = stopCnt;
        repeat (20000) @(posedge iCLK);
        #1;
        checkOutput("holdStarts", startCnt - s0, 0);
        checkOutput("holdStops", stopCnt - p0, 0);
        checkOutput("holdEnd", endSig, 1'b1);
        checkOutput("holdScl", scl, 1'b1);

        // Switch to the QDIV=2 instance; drop GO first so the switch is not a rising edge.
        go = 1'b0;
        @(posedge iCLK); #1;
        sel = 1'b1;
        @(posedge iCLK); #1;

        applyStimulus(24'h200227, 3'b111, 1'b0);
        waitEnd(232, 0, "fast");
        applyStimulus(24'hc00253, 3'b101, 1'b1);
        waitEnd(232, 0, "nack");
        applyStimulus(24'hc00253, 3'b111, 1'b0);
        waitEnd(232, 0, "retry");
        applyStimulus(24'h5a3cc3, 3'b111, 1'b0);
        waitEnd(232, 60, "toggle");

        // Abort mid sub-address byte after the address byte was NACKed.
        applyStimulus(24'h200227, 3'b110, 1'b1);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge iCLK); #1;
            if (byteNum == 1 && bitIdx == 4) found = 1;
        end
        checkOutput("rstPointReached", found, 1);
        checkOutput("preRstAck", ackSig, 1'b1);
        iRST = 1'b1;
        @(posedge iCLK); #1;
        checkOutput("midRstScl", scl, 1'b1);
        checkOutput("midRstSda", sdaLine === 1'b0, 1'b0);
        checkOutput("midRstEnd", endSig, 1'b0);
        checkOutput("midRstAck", ackSig, 1'b0);
        iRST = 1'b0;
        expQ.delete();
        expAckQ.delete();
        pushFrame(24'h200227, 3'b111, 1'b0);
        waitEnd(232, 0, "afterRst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
